// File: rtl/ram_port_arbiter_if.sv
// Requester-side access bundle for ram_port_arbiter.
// master = CPU/host requester, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic              ack;
  logic [63:0]       rdata;

  modport master (
    output req, we, size, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter serialising 1/4/8-byte accesses onto a byte RAM.
// Ports: clk, rst (async high), cpu/host slave bundles, ram_addr/we/d/q,
// busy (not IDLE), owner (0 = CPU, 1 = host; current or last grant).
module ram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave cpu,
  ram_port_arbiter_if.slave host,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_d,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_d;

  logic              we_q;
  logic [2:0]        last_q;
  logic [ADDR_W-1:0] base_q;
  logic [63:0]       wdata_q;
  logic [63:0]       asm_q;
  logic [63:0]       cpu_rdata_q;
  logic [63:0]       host_rdata_q;
  logic [2:0]        cnt;
  logic              owner_q;
  // 1 = host was granted last, so CPU wins the next contest
  logic              host_last;

  logic              grant_any;
  logic              grant_host;
  logic              g_we;
  logic [1:0]        g_size;
  logic [ADDR_W-1:0] g_addr;
  logic [63:0]       g_wdata;
  logic [2:0]        g_last;
  logic [2:0]        prev;
  logic [63:0]       asm_fin;
  logic              cpu_ack_c;
  logic              host_ack_c;

  always_comb begin
    grant_any  = cpu.req | host.req;
    grant_host = host.req &
                 (~cpu.req | (RR_EN & ~host_last));
    g_we    = grant_host ? host.we    : cpu.we;
    g_size  = grant_host ? host.size  : cpu.size;
    g_addr  = grant_host ? host.addr  : cpu.addr;
    g_wdata = grant_host ? host.wdata : cpu.wdata;
    unique case (g_size)
      2'b10:   g_last = 3'd3;
      2'b11:   g_last = 3'd7;
      default: g_last = 3'd0;
    endcase
  end

  // ram_q lags the address by one cycle
  assign prev = cnt - 3'd1;

  always_comb begin
    asm_fin = asm_q;
    asm_fin[{last_q, 3'b000} +: 8] = ram_q;
  end

  always_comb begin
    state_d    = state;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_d      = '0;
    cpu_ack_c  = 1'b0;
    host_ack_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any) state_d = XFER;
      end
      XFER: begin
        ram_addr = base_q + ADDR_W'(cnt);
        ram_we   = we_q;
        if (we_q) ram_d = wdata_q[{cnt, 3'b000} +: 8];
        if (cnt == last_q) state_d = we_q ? DONE : DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        state_d    = IDLE;
        cpu_ack_c  = ~owner_q;
        host_ack_c = owner_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      last_q       <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      cnt          <= '0;
      owner_q      <= 1'b0;
      host_last    <= 1'b1;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            owner_q   <= grant_host;
            host_last <= grant_host;
            we_q      <= g_we;
            last_q    <= g_last;
            base_q    <= g_addr;
            wdata_q   <= g_wdata;
            cnt       <= '0;
            asm_q     <= '0;
          end
        end
        XFER: begin
          cnt <= cnt + 3'd1;
          if (!we_q && cnt != 3'd0)
            asm_q[{prev, 3'b000} +: 8] <= ram_q;
        end
        DRAIN: begin
          if (owner_q) host_rdata_q <= asm_fin;
          else         cpu_rdata_q  <= asm_fin;
        end
        DONE: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign owner      = owner_q;
  assign cpu.ack    = cpu_ack_c;
  assign host.ack   = host_ack_c;
  assign cpu.rdata  = cpu_rdata_q;
  assign host.rdata = host_rdata_q;

endmodule
